// File: rtl/pipeline_pkg.sv
// Shared pipeline-control definitions.
//   - Forwarding select encodings for the execute-stage operand muxes.
//   - Scoreboard entry types: a tag {valid, rd, wEn} plus the load flag.
//   - REG_ZERO and a helper that decides whether a tag supplies a source.
package pipeline_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    // Scoreboard stage indices, youngest first.
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;
    localparam int SB_DEPTH = 3;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
    } sb_tag_t;

    typedef struct packed {
        sb_tag_t tag;
        logic    is_load;
    } sb_entry_t;

    // A tag supplies a source when it is a real, writing instruction whose
    // destination is a non-zero register equal to a source that is read.
    function automatic logic tag_matches(sb_tag_t t, logic use_src, logic [4:0] src);
        return t.valid && t.wen && (t.rd != REG_ZERO) && use_src && (t.rd == src);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-deep scoreboard of in-flight destination registers (EX, MEM, WB).
// Ports:
//   clock, reset           - clock and synchronous active-high reset
//   issue_entry            - entry entering EX this edge (bubble already applied)
//   src1/src2, use_src1/2  - decode-stage sources and their read flags
//   ex_is_load             - the EX entry is a valid load
//   match_src1/match_src2  - per-stage match of each source, index SB_EX..SB_WB
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  sb_entry_t           issue_entry,
    input  logic [4:0]          src1,
    input  logic [4:0]          src2,
    input  logic                use_src1,
    input  logic                use_src2,
    output logic                ex_is_load,
    output logic [SB_DEPTH-1:0] match_src1,
    output logic [SB_DEPTH-1:0] match_src2
);

    // The load flag only matters while the producer sits in EX; once it has
    // reached MEM its data is forwardable, so older stages keep just the tag.
    sb_tag_t [SB_DEPTH-1:0] tag_q;
    sb_tag_t [SB_DEPTH-1:0] tag_d;
    logic                   ex_is_load_q;
    logic                   ex_is_load_d;

    always_comb begin
        tag_d        = tag_q;
        tag_d[SB_EX] = issue_entry.tag;
        for (int i = 1; i < SB_DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        ex_is_load_d = issue_entry.tag.valid && issue_entry.is_load;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q        <= '0;
            ex_is_load_q <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            ex_is_load_q <= ex_is_load_d;
        end
    end

    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
        assign match_src1[gi] = tag_matches(tag_q[gi], use_src1, src1);
        assign match_src2[gi] = tag_matches(tag_q[gi], use_src2, src2);
    end

    assign ex_is_load = ex_is_load_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: RAW stall detection, post-redirect flush
// sequencing, registered operand-forwarding selects and saturating
// performance counters.
// Ports:
//   clock, reset                  - clock and synchronous active-high reset
//   dec_*                         - instruction currently in decode
//   redirect                      - taken branch / jump changes the PC
//   STALL                         - hold fetch/decode, bubble into EX
//   DUMP                          - squash fetch/decode and decode/execute
//   fwd_A_sel, fwd_B_sel          - EX operand sources (FWD_* encoding)
//   stall_count, flush_count      - saturating STALL-cycle / redirect counts
// Parameters:
//   FORWARDING   - 1: stall only on load-use; 0: stall on any RAW in EX/MEM/WB
//   FLUSH_CYCLES - cycles DUMP stays high after a redirect (1..3)
//   CNT_BITS     - width of the performance counters
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int FORWARDING   = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_BITS     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [4:0]          dec_rs1,
    input  logic [4:0]          dec_rs2,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  logic [4:0]          dec_rd,
    input  logic                dec_wEn,
    input  logic                dec_is_load,
    input  logic                redirect,
    output logic                STALL,
    output logic                DUMP,
    output logic [1:0]          fwd_A_sel,
    output logic [1:0]          fwd_B_sel,
    output logic [CNT_BITS-1:0] stall_count,
    output logic [CNT_BITS-1:0] flush_count
);

    localparam logic [1:0]          FLUSH_LOAD = 2'(FLUSH_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

    sb_entry_t           issue_entry;
    logic [SB_DEPTH-1:0] match_rs1;
    logic [SB_DEPTH-1:0] match_rs2;
    logic                ex_is_load;
    logic                load_use;
    logic                any_raw;
    logic                dump;
    logic                stall;

    logic [1:0]          flush_ctr_q, flush_ctr_d;
    logic [1:0]          fwd_a_q, fwd_a_d;
    logic [1:0]          fwd_b_q, fwd_b_d;
    logic [CNT_BITS-1:0] stall_count_q, stall_count_d;
    logic [CNT_BITS-1:0] flush_count_q, flush_count_d;

    hazard_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_entry (issue_entry),
        .src1        (dec_rs1),
        .src2        (dec_rs2),
        .use_src1    (dec_use_rs1),
        .use_src2    (dec_use_rs2),
        .ex_is_load  (ex_is_load),
        .match_src1  (match_rs1),
        .match_src2  (match_rs2)
    );

    // The youngest producer wins: EX/MEM data is newer than MEM/WB data.
    function automatic logic [1:0] fwd_pick(logic ex_hit, logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end
        if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

    always_comb begin
        dump     = (flush_ctr_q != 2'd0);
        load_use = ex_is_load && (match_rs1[SB_EX] || match_rs2[SB_EX]);
        any_raw  = (|match_rs1) || (|match_rs2);
        // A flush already discards the decode instruction, so it overrides STALL.
        stall    = dec_valid && !dump && ((FORWARDING != 0) ? load_use : any_raw);

        issue_entry = '0;
        if (dec_valid && !stall && !dump) begin
            issue_entry.tag.valid = 1'b1;
            issue_entry.tag.rd    = dec_rd;
            issue_entry.tag.wen   = dec_wEn;
            issue_entry.is_load   = dec_is_load;
        end

        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if ((FORWARDING != 0) && issue_entry.tag.valid) begin
            fwd_a_d = fwd_pick(match_rs1[SB_EX], match_rs1[SB_MEM]);
            fwd_b_d = fwd_pick(match_rs2[SB_EX], match_rs2[SB_MEM]);
        end

        // A redirect during a flush restarts the full flush window.
        flush_ctr_d = flush_ctr_q;
        if (redirect) begin
            flush_ctr_d = FLUSH_LOAD;
        end else if (flush_ctr_q != 2'd0) begin
            flush_ctr_d = flush_ctr_q - 2'd1;
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end

        flush_count_d = flush_count_q;
        if (redirect && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flush_ctr_q   <= 2'd0;
            fwd_a_q       <= FWD_REG;
            fwd_b_q       <= FWD_REG;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            flush_ctr_q   <= flush_ctr_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign STALL       = stall;
    assign DUMP        = dump;
    assign fwd_A_sel   = fwd_a_q;
    assign fwd_B_sel   = fwd_b_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit. Two instances share one decode stream:
//   dut1: FORWARDING=1, FLUSH_CYCLES=2, CNT_BITS=16
//   dut0: FORWARDING=0, FLUSH_CYCLES=3, CNT_BITS=4 (small width reaches saturation quickly)
// A distance-based model of the issued instruction stream is checked every
// cycle; directed scenarios add hand-computed literal expectations.
module tb_hazard_control_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_use_rs1, dec_use_rs2, dec_wEn, dec_is_load;
    logic       redirect;

    logic        stall1, dump1;
    logic [1:0]  fa1, fb1;
    logic [15:0] sc1, fc1;
    logic        stall0, dump0;
    logic [1:0]  fa0, fb0;
    logic [3:0]  sc0, fc0;

    hazard_control_unit #(.FORWARDING(1), .FLUSH_CYCLES(2), .CNT_BITS(16)) dut1 (
        .clock(clock), .reset(reset), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_wEn(dec_wEn), .dec_is_load(dec_is_load),
        .redirect(redirect), .STALL(stall1), .DUMP(dump1),
        .fwd_A_sel(fa1), .fwd_B_sel(fb1),
        .stall_count(sc1), .flush_count(fc1)
    );

    hazard_control_unit #(.FORWARDING(0), .FLUSH_CYCLES(3), .CNT_BITS(4)) dut0 (
        .clock(clock), .reset(reset), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_wEn(dec_wEn), .dec_is_load(dec_is_load),
        .redirect(redirect), .STALL(stall0), .DUMP(dump0),
        .fwd_A_sel(fa0), .fwd_B_sel(fb0),
        .stall_count(sc0), .flush_count(fc0)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models dut1, index 1 models dut0.
    typedef struct { bit valid; int rd; bit wen; bit ld; } instr_t;

    int cfg_fwd   [2] = '{1, 0};
    int cfg_flush [2] = '{2, 3};
    int cfg_max   [2] = '{65535, 15};

    instr_t hist [2][3];          // issued stream, hist[m][k] issued k+1 cycles ago
    int     exp_fa [2];
    int     exp_fb [2];
    int     exp_sc [2];
    int     exp_fc [2];
    int     last_redir [2];
    int     cyc = 0;

    // Age (1..3) of the most recent issued producer of rs, 0 if none.
    function automatic int producer_age(int m, int rs, bit use_it);
        if (!use_it || rs == 0) return 0;
        for (int k = 0; k < 3; k++) begin
            if (hist[m][k].valid && hist[m][k].wen && hist[m][k].rd == rs) return k + 1;
        end
        return 0;
    endfunction

    function automatic int age_to_sel(int age);
        if (age == 1) return 1;
        if (age == 2) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) hist[m][k] = '{0, 0, 0, 0};
            exp_fa[m] = 0; exp_fb[m] = 0; exp_sc[m] = 0; exp_fc[m] = 0;
            last_redir[m] = -100;
        end
    endtask

    initial model_reset();

    always @(negedge clock) begin
        int a1, a2, act_stall, act_dump, act_fa, act_fb, act_sc, act_fc;
        bit dump_e, stall_e, raw;
        instr_t ni;
        if (checking) begin
            for (int m = 0; m < 2; m++) begin
                a1 = producer_age(m, int'(dec_rs1), dec_use_rs1);
                a2 = producer_age(m, int'(dec_rs2), dec_use_rs2);
                dump_e = (cyc - last_redir[m] >= 1) && (cyc - last_redir[m] <= cfg_flush[m]);
                if (cfg_fwd[m] != 0)
                    raw = hist[m][0].ld && (a1 == 1 || a2 == 1);
                else
                    raw = (a1 != 0) || (a2 != 0);
                stall_e = dec_valid && raw && !dump_e;

                act_stall = (m == 0) ? int'(stall1) : int'(stall0);
                act_dump  = (m == 0) ? int'(dump1)  : int'(dump0);
                act_fa    = (m == 0) ? int'(fa1)    : int'(fa0);
                act_fb    = (m == 0) ? int'(fb1)    : int'(fb0);
                act_sc    = (m == 0) ? int'(sc1)    : int'(sc0);
                act_fc    = (m == 0) ? int'(fc1)    : int'(fc0);
                check($sformatf("model dut%0d STALL", 1 - m), act_stall, int'(stall_e));
                check($sformatf("model dut%0d DUMP", 1 - m), act_dump, int'(dump_e));
                check($sformatf("model dut%0d fwd_A_sel", 1 - m), act_fa, exp_fa[m]);
                check($sformatf("model dut%0d fwd_B_sel", 1 - m), act_fb, exp_fb[m]);
                check($sformatf("model dut%0d stall_count", 1 - m), act_sc, exp_sc[m]);
                check($sformatf("model dut%0d flush_count", 1 - m), act_fc, exp_fc[m]);

                if (!reset) begin
                    ni.valid = dec_valid && !stall_e && !dump_e;
                    ni.rd    = int'(dec_rd);
                    ni.wen   = dec_wEn;
                    ni.ld    = dec_is_load;
                    if (ni.valid && cfg_fwd[m] != 0) begin
                        exp_fa[m] = age_to_sel(a1);
                        exp_fb[m] = age_to_sel(a2);
                    end else begin
                        exp_fa[m] = 0;
                        exp_fb[m] = 0;
                    end
                    hist[m][2] = hist[m][1];
                    hist[m][1] = hist[m][0];
                    hist[m][0] = ni;
                    if (stall_e && exp_sc[m] < cfg_max[m]) exp_sc[m]++;
                    if (redirect && exp_fc[m] < cfg_max[m]) exp_fc[m]++;
                    if (redirect) last_redir[m] = cyc;
                end
            end
            if (reset) model_reset();
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit v, int rs1, int rs2, bit u1, bit u2,
                         int rd, bit w, bit ld, bit rdr);
        @(posedge clock);
        #1;
        dec_valid   = v;
        dec_rs1     = rs1[4:0];
        dec_rs2     = rs2[4:0];
        dec_use_rs1 = u1;
        dec_use_rs2 = u2;
        dec_rd      = rd[4:0];
        dec_wEn     = w;
        dec_is_load = ld;
        redirect    = rdr;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        dec_rd = 0; dec_wEn = 0; dec_is_load = 0; redirect = 0;
        @(posedge clock); #1 checking = 1;
        @(posedge clock); #1 reset = 1'b0;
        #2;
        check("reset STALL", int'(stall1), 0);
        check("reset DUMP", int'(dump1), 0);
        check("reset fwd_A_sel", int'(fa1), 0);
        check("reset fwd_B_sel", int'(fb1), 0);
        check("reset stall_count", int'(sc1), 0);
        check("reset flush_count dut0", int'(fc0), 0);
        idle(1);

        // load x5 ; add x6,x5,x7 (held while stalled)
        drive(1, 1, 0, 1, 0, 5, 1, 1, 0);
        drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
        #2 check("load-use STALL cycle1", int'(stall1), 1);
        drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
        #2 check("load-use STALL cycle2", int'(stall1), 0);
        idle(1);
        #2 check("load-use fwd_A_sel", int'(fa1), 2);
        check("load-use fwd_B_sel", int'(fb1), 0);
        check("load-use stall_count", int'(sc1), 1);
        idle(3);

        // add x5 ; sub x8,x1,x5
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
        drive(1, 1, 5, 1, 1, 8, 1, 0, 0);
        #2 check("b2b STALL", int'(stall1), 0);
        idle(1);
        #2 check("b2b fwd_B_sel", int'(fb1), 1);
        check("b2b fwd_A_sel", int'(fa1), 0);
        idle(3);

        // add x5 ; add x9,x1,x2 ; sub x8,x1,x5
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
        drive(1, 1, 2, 1, 1, 9, 1, 0, 0);
        drive(1, 1, 5, 1, 1, 8, 1, 0, 0);
        idle(1);
        #2 check("gap1 fwd_B_sel", int'(fb1), 2);
        idle(3);

        // addi x3,x0 ; add x4,x3,x3 held four cycles (no-forwarding instance)
        drive(1, 0, 0, 1, 0, 3, 1, 0, 0);
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0);
        #2 check("nofwd STALL c1", int'(stall0), 1);
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0);
        #2 check("nofwd STALL c2", int'(stall0), 1);
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0);
        #2 check("nofwd STALL c3", int'(stall0), 1);
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0);
        #2 check("nofwd STALL c4", int'(stall0), 0);
        idle(1);
        #2 check("nofwd fwd_A_sel", int'(fa0), 0);
        check("nofwd fwd_B_sel", int'(fb0), 0);
        idle(3);

        // single redirect, then redirect at t and t+2
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        #2 check("flush t+1 DUMP", int'(dump1), 1);
        check("flush flush_count", int'(fc1), 1);
        idle(1);
        #2 check("flush t+2 DUMP", int'(dump1), 1);
        idle(1);
        #2 check("flush t+3 DUMP", int'(dump1), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        #2 check("reflush u+1 DUMP", int'(dump1), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2 check("reflush u+2 DUMP", int'(dump1), 1);
        idle(1);
        #2 check("reflush u+3 DUMP", int'(dump1), 1);
        idle(1);
        #2 check("reflush u+4 DUMP", int'(dump1), 1);
        idle(1);
        #2 check("reflush u+5 DUMP", int'(dump1), 0);
        check("reflush flush_count", int'(fc1), 3);
        idle(3);

        // load x5 redirecting, then dependent add during the flush
        drive(1, 1, 0, 1, 0, 5, 1, 1, 1);
        drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
        #2 check("dump-prio DUMP", int'(dump1), 1);
        check("dump-prio STALL", int'(stall1), 0);
        drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
        #2 check("dump-prio STALL c2", int'(stall1), 0);
        check("dump-prio bubble fwd_A_sel", int'(fa1), 0);
        drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
        #2 check("post-flush DUMP", int'(dump1), 0);
        check("post-flush STALL", int'(stall1), 0);
        idle(1);
        #2 check("post-flush fwd_A_sel", int'(fa1), 0);
        idle(3);

        // reset while flush_ctr=2
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        reset = 1'b1;
        #2 check("pre-reset DUMP", int'(dump1), 1);
        idle(1);
        reset = 1'b0;
        #2 check("abort DUMP", int'(dump1), 0);
        check("abort STALL", int'(stall1), 0);
        check("abort fwd_A_sel", int'(fa1), 0);
        check("abort fwd_B_sel", int'(fb1), 0);
        check("abort stall_count", int'(sc1), 0);
        check("abort flush_count", int'(fc1), 0);
        idle(1);

        // x0 as destination never creates a hazard or forward
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 1, 7, 1, 0, 0);
        #2 check("x0 STALL fwd", int'(stall1), 0);
        check("x0 STALL nofwd", int'(stall0), 0);
        drive(1, 1, 0, 1, 0, 0, 1, 1, 0);
        #2 check("x0 fwd_A_sel", int'(fa1), 0);
        check("x0 fwd_B_sel", int'(fb1), 0);
        drive(1, 0, 0, 1, 1, 7, 1, 0, 0);
        #2 check("x0 load STALL fwd", int'(stall1), 0);
        check("x0 load STALL nofwd", int'(stall0), 0);
        idle(1);
        #2 check("x0 load fwd_A_sel", int'(fa1), 0);
        check("x0 load fwd_B_sel", int'(fb1), 0);
        idle(3);

        // saturation of the 4-bit counters
        repeat (80) drive(1, 3, 0, 1, 0, 3, 1, 0, 0);
        idle(1);
        #2 check("sat stall_count dut0", int'(sc0), 15);
        check("sat stall_count dut1", int'(sc1), 0);
        repeat (20) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        #2 check("sat flush_count dut0", int'(fc0), 15);
        check("sat flush_count dut1", int'(fc1), 20);
        idle(4);

        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer side of the pipeline-control interface. Generates STALL and DUMP, which Fetch_Decode_Moderator and Decode_Execute_Moderator consume, plus registered operand-forwarding selects for the execute stage.
- Keeps a 3-deep scoreboard of in-flight destination registers (EX, MEM, WB). Detects RAW hazards against the instruction in decode, and sequences multi-cycle flushes after a PC redirect (taken branch, JAL, JALR).

Parameters:
- FORWARDING, 1: 1 = use forwarding and stall only on load-use; 0 = stall on any RAW match in EX, MEM or WB.
- FLUSH_CYCLES, 2: number of consecutive cycles DUMP stays asserted after a redirect; legal range 1-3.
- CNT_BITS, 16: width of the saturating performance counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dec_valid  in  1  decode holds a real instruction
- dec_rs1  in  5  decode source register 1
- dec_rs2  in  5  decode source register 2
- dec_use_rs1  in  1  instruction reads rs1
- dec_use_rs2  in  1  instruction reads rs2
- dec_rd  in  5  decode destination register
- dec_wEn  in  1  instruction writes rd
- dec_is_load  in  1  instruction is a load (writeback from memory)
- redirect  in  1  next_PC_select asserted for a taken branch or jump
- STALL  out  1  hold fetch and decode, inject a bubble into EX
- DUMP  out  1  squash the fetch/decode and decode/execute contents
- fwd_A_sel  out  2  EX operand A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback data
- fwd_B_sel  out  2  EX operand B source, same encoding as fwd_A_sel
- stall_count  out  CNT_BITS  saturating count of STALL cycles
- flush_count  out  CNT_BITS  saturating count of redirect events

Behaviour:
- Reset:
  - All scoreboard entries invalid.
  - STALL=0, DUMP=0, fwd_*_sel=00, counters=0, flush counter=0.
  - Reset asserted mid-flush or mid-stall aborts the flush or stall on the next edge.
- Scoreboard entry = {valid, rd, wEn, is_load}. Each clock edge:
  - WB<=MEM and MEM<=EX.
  - EX<=decode entry, unless STALL or DUMP is active that cycle. In that case EX<=bubble (valid=0).
- Match definition: an entry matches a source register when entry.valid, entry.wEn, entry.rd != 0, the register use flag is set, and rd equals the source register.
- STALL is combinational from the current scoreboard and the decode inputs:
  - FORWARDING=1: STALL = dec_valid and the EX entry is a load that matches rs1 or rs2. This is always exactly 1 cycle, because after the bubble the load sits in MEM and is forwarded from WB.
  - FORWARDING=0: STALL = dec_valid and any of EX, MEM or WB matches. The regfile writes at the edge, so a WB match also stalls.
  - STALL is forced to 0 whenever DUMP=1 (DUMP has priority).
- DUMP, registered:
  - A redirect loads flush_ctr with FLUSH_CYCLES. DUMP = (flush_ctr != 0). The counter decrements each cycle while nonzero.
  - A redirect while flush_ctr != 0 reloads it to FLUSH_CYCLES.
  - The instruction that caused the redirect has already advanced and is not squashed.
- Forwarding selects are registered. They are computed from the decode sources and updated on the same edge that moves decode into EX:
  - 01 if the current EX entry matches, which takes priority over 10.
  - 10 if the current MEM entry matches.
  - 00 otherwise.
  - Outputs are 00 when the entry moved into EX is a bubble, or when FORWARDING=0.
- Counters:
  - stall_count increments on every cycle with STALL=1.
  - flush_count increments on every cycle with redirect=1.
  - Both hold at 2^CNT_BITS-1.
- x0 never causes a hazard or a forward.

Decomposition:
- Shared package pipeline_pkg holds:
  - FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The scoreboard entry struct/typedef.
  - REG_ZERO=5'd0.
- One natural sub-module, hazard_scoreboard: the 3-entry shift register plus the per-entry match outputs. The stall, flush and forwarding logic stays in the parent.

Test Plan:
- FORWARDING=1, load x5 then add x6,x5,x7 -> STALL=1 for exactly 1 cycle, stall_count=1, next cycle fwd_A_sel=10.
- FORWARDING=1, add x5 then sub x8,x1,x5 back-to-back -> no STALL, fwd_B_sel=01. With one independent instruction between them -> fwd_B_sel=10.
- FORWARDING=0, addi x3 then add x4,x3,x3 -> STALL for 3 cycles, fwd selects stay 00.
- FLUSH_CYCLES=2, single-cycle redirect -> DUMP high for cycles t+1 and t+2 only, flush_count=1. A second redirect at t+2 -> DUMP extended through t+4.
- Load-use hazard coinciding with redirect -> DUMP=1, STALL=0, bubble in EX. Reset asserted while flush_ctr=2 -> DUMP=0 and all outputs zero on the next edge.
- Writes to x0 followed by reads of x0 -> no STALL and fwd selects 00. Drive 2^16 stall cycles -> stall_count holds at 16'hFFFF.
